memory_sequencer: RTL and testbench
===================================

// Module: memory_sequencer
// PURPOSE
//  Initiator for the memory block's op/selector interface: turns fetch, jump,
//  load and store requests from the control unit into the cycle-exact
//  memory_op_e / memory_bus_selector_e / word-select / data sequences the memory expects.
//  Fetches 16-bit instruction words through PC and moves data bytes through MAR.
//  Sits between the control unit (request/response side) and memory (mem_* side).
// PARAMETERS
//  READ_CYCLES  2  cycles op=READ is held per byte (legal >=2); bus sampled on the last one
// PORTS
//  clock         in   1   single clock; all state on posedge
//  reset_n       in   1   asynchronous, active-low reset
//  req_valid     in   1   request present
//  req_ready     out  1   =1 only in IDLE; request accepted on posedge with valid&ready
//  req_kind      in   3   0 FETCH,1 JUMP_ABS,2 JUMP_ADD,3 JUMP_SUB,4 LOAD,5 STORE,6-7 illegal
//  req_addr      in   8   jump target/offset, or MAR address for LOAD/STORE
//  req_wdata     in   8   STORE data
//  req_word      in   1   data word select for LOAD/STORE
//  rsp_valid     out  1   one-cycle pulse: request complete
//  rsp_data      out  16  FETCH {hi,lo}; LOAD {8'h00,byte}; else 16'h0000; held until next rsp
//  mem_op        out  memory_op_e           op to memory
//  mem_bus_sel   out  memory_bus_selector_e 0 MAR, 1 PC
//  mem_word_sel  out  1   memory data_word_selector
//  mem_in        out  8   data/offset to memory 'in'
//  mem_out       in   8   memory 'out' (driven only while op==READ)
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, mem_op=NOP, mem_bus_sel=MAR, mem_word_sel=0,
//   mem_in=0, rsp_valid=0, rsp_data=0; req_ready=1 once in IDLE. Reset mid-request
//   aborts it with no rsp; memory PC/MAR keep whatever already happened.
//  All mem_* and rsp_* outputs registered. req_kind/addr/wdata/word latched at accept.
//  States: IDLE, RD_LO, RD_HI, PC_INC, SET_MAR, RD_DATA, WR_DATA, JUMP, DONE.
//  FETCH: RD_LO (READ,PC,word 0) x READ_CYCLES, capture mem_out as lo on last cycle;
//   RD_HI (READ,PC,word 1) x READ_CYCLES, capture hi; PC_INC (INC,PC) 1 cycle; DONE.
//  JUMP_*: JUMP 1 cycle: op ABSOLUTE/REL_ADD/REL_SUB, bus PC, mem_in=req_addr; DONE.
//  LOAD: SET_MAR (ABSOLUTE,MAR,mem_in=req_addr) 1 cycle; RD_DATA (READ,MAR,req_word)
//   x READ_CYCLES, capture on last; DONE.
//  STORE: SET_MAR 1 cycle; WR_DATA (WRITE,MAR,req_word,mem_in=req_wdata) 1 cycle; DONE.
//  Illegal kind: accepted, straight to DONE, rsp_data=16'h0000, no mem op issued.
//  DONE: mem_op=NOP, rsp_valid=1 for exactly 1 cycle, then IDLE.
//  Outside listed states mem_op=NOP; mem_in=0 except where specified.
//  Latency (READ_CYCLES=2, accept edge = 0): FETCH rsp_valid in cycle 6, LOAD 4,
//   STORE 3, JUMP 2, illegal 1. Next request acceptable in cycle after DONE.
//  req_valid while busy: ignored, not queued; requester must hold it until ready.
//  PC/MAR width wrap-around is the memory's; sequencer does no address arithmetic.
//  Read cycle counter width ceil(log2(READ_CYCLES+1)); resets per byte.
// TESTING
//  Reset: reset_n=0 mid-activity -> mem_op=NOP, rsp_valid=0, rsp_data=0, req_ready=1 after.
//  Cells[{PC=0,0}]=8'h34,[{0,1}]=8'h12; FETCH -> rsp_data=16'h1234 cycle 6, PC then 1.
//  STORE addr 8'h05 word 1 data 8'hA5, then LOAD 8'h05 word 1 -> rsp_data=16'h00A5.
//  PC=8'h10, JUMP_SUB 8'h03 then FETCH -> fetch reads cells at PC 8'h0D.
//  req_valid held with FETCH during busy STORE -> only one op sequence live; FETCH after DONE.
//  reset_n pulse during RD_HI -> no rsp_valid; next FETCH completes normally.

Source files
------------

// File: rtl/memory_sequencer.sv
// memory_sequencer
//   Initiator for the memory block's op/selector interface. Turns FETCH, JUMP,
//   LOAD and STORE requests from the control unit into cycle-exact op / bus
//   selector / word select / data sequences. Instruction words (16 bit) come in
//   through PC as two bytes; data bytes move through MAR.
//
//   Ports
//     clock, reset_n                  clock, async active-low reset
//     req_valid/req_ready             request handshake (ready only in IDLE)
//     req_kind/addr/wdata/word        request fields, latched at accept
//     rsp_valid/rsp_data              one-cycle completion pulse, held data
//     mem_op/mem_bus_sel/mem_word_sel/mem_in   registered drive to memory
//     mem_out                         memory read data (valid while op==READ)
//
//   Every mem_* output is the registered decode of the state held in the
//   previous cycle, so a state's memory action appears one cycle after the
//   state is entered. Read data is therefore sampled one cycle after the last
//   read state, which for LOAD is the edge that leaves DONE.

package memory_pkg;
    typedef enum logic [2:0] {
        NOP      = 3'd0,
        READ     = 3'd1,
        WRITE    = 3'd2,
        INC      = 3'd3,
        ABSOLUTE = 3'd4,
        REL_ADD  = 3'd5,
        REL_SUB  = 3'd6
    } memory_op_e;

    typedef enum logic {
        MAR = 1'b0,
        PC  = 1'b1
    } memory_bus_selector_e;
endpackage

// state   | meaning
// IDLE    | waiting for a request, req_ready=1
// RD_LO   | reading instruction low byte through PC (READ_CYCLES cycles)
// RD_HI   | reading instruction high byte through PC (READ_CYCLES cycles)
// PC_INC  | incrementing PC after a fetch
// SET_MAR | loading MAR with the request address
// RD_DATA | reading a data byte through MAR (READ_CYCLES cycles)
// WR_DATA | writing a data byte through MAR
// JUMP    | absolute / relative PC update
// DONE    | request complete, response issued next cycle
module memory_sequencer
    import memory_pkg::*;
#(
    parameter int READ_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_kind,
    input  logic [7:0]           req_addr,
    input  logic [7:0]           req_wdata,
    input  logic                 req_word,
    output logic                 rsp_valid,
    output logic [15:0]          rsp_data,
    output memory_op_e           mem_op,
    output memory_bus_selector_e mem_bus_sel,
    output logic                 mem_word_sel,
    output logic [7:0]           mem_in,
    input  logic [7:0]           mem_out
);

    localparam int CNT_W = $clog2(READ_CYCLES + 1);

    localparam logic [2:0] K_FETCH    = 3'd0;
    localparam logic [2:0] K_JUMP_ABS = 3'd1;
    localparam logic [2:0] K_JUMP_ADD = 3'd2;
    localparam logic [2:0] K_JUMP_SUB = 3'd3;
    localparam logic [2:0] K_LOAD     = 3'd4;
    localparam logic [2:0] K_STORE    = 3'd5;

    typedef enum logic [3:0] {
        IDLE, RD_LO, RD_HI, PC_INC, SET_MAR, RD_DATA, WR_DATA, JUMP, DONE
    } state_e;

    state_e               state, state_nxt;
    logic [CNT_W-1:0]     rd_cnt, rd_cnt_nxt;
    logic                 rd_last;
    logic                 accept;
    logic [2:0]           kind_q;
    logic [7:0]           addr_q, wdata_q;
    logic                 word_q;
    logic [7:0]           lo_q, hi_q;
    logic                 cap_lo_q, cap_hi_q, cap_lo_nxt, cap_hi_nxt;
    memory_op_e           op_nxt;
    memory_bus_selector_e bus_nxt;
    logic                 word_nxt;
    logic [7:0]           in_nxt;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign rd_last   = (rd_cnt == CNT_W'(READ_CYCLES - 1));

    always_comb begin
        state_nxt  = state;
        rd_cnt_nxt = '0;
        op_nxt     = NOP;
        bus_nxt    = MAR;
        word_nxt   = 1'b0;
        in_nxt     = 8'h00;
        cap_lo_nxt = 1'b0;
        cap_hi_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (req_kind)
                        K_FETCH:                            state_nxt = RD_LO;
                        K_JUMP_ABS, K_JUMP_ADD, K_JUMP_SUB: state_nxt = JUMP;
                        K_LOAD, K_STORE:                    state_nxt = SET_MAR;
                        default:                            state_nxt = DONE;
                    endcase
                end
            end
            RD_LO: begin
                op_nxt  = READ;
                bus_nxt = PC;
                if (rd_last) begin
                    cap_lo_nxt = 1'b1;
                    state_nxt  = RD_HI;
                end else begin
                    rd_cnt_nxt = rd_cnt + 1'b1;
                end
            end
            RD_HI: begin
                op_nxt   = READ;
                bus_nxt  = PC;
                word_nxt = 1'b1;
                if (rd_last) begin
                    cap_hi_nxt = 1'b1;
                    state_nxt  = PC_INC;
                end else begin
                    rd_cnt_nxt = rd_cnt + 1'b1;
                end
            end
            PC_INC: begin
                op_nxt    = INC;
                bus_nxt   = PC;
                state_nxt = DONE;
            end
            SET_MAR: begin
                op_nxt    = ABSOLUTE;
                in_nxt    = addr_q;
                state_nxt = (kind_q == K_LOAD) ? RD_DATA : WR_DATA;
            end
            RD_DATA: begin
                op_nxt   = READ;
                word_nxt = word_q;
                if (rd_last) state_nxt = DONE;
                else         rd_cnt_nxt = rd_cnt + 1'b1;
            end
            WR_DATA: begin
                op_nxt    = WRITE;
                word_nxt  = word_q;
                in_nxt    = wdata_q;
                state_nxt = DONE;
            end
            JUMP: begin
                case (kind_q)
                    K_JUMP_ADD: op_nxt = REL_ADD;
                    K_JUMP_SUB: op_nxt = REL_SUB;
                    default:    op_nxt = ABSOLUTE;
                endcase
                bus_nxt   = PC;
                in_nxt    = addr_q;
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            rd_cnt       <= '0;
            mem_op       <= NOP;
            mem_bus_sel  <= MAR;
            mem_word_sel <= 1'b0;
            mem_in       <= 8'h00;
            cap_lo_q     <= 1'b0;
            cap_hi_q     <= 1'b0;
            kind_q       <= 3'd0;
            addr_q       <= 8'h00;
            wdata_q      <= 8'h00;
            word_q       <= 1'b0;
            lo_q         <= 8'h00;
            hi_q         <= 8'h00;
            rsp_valid    <= 1'b0;
            rsp_data     <= 16'h0000;
        end else begin
            state        <= state_nxt;
            rd_cnt       <= rd_cnt_nxt;
            mem_op       <= op_nxt;
            mem_bus_sel  <= bus_nxt;
            mem_word_sel <= word_nxt;
            mem_in       <= in_nxt;
            cap_lo_q     <= cap_lo_nxt;
            cap_hi_q     <= cap_hi_nxt;
            if (accept) begin
                kind_q  <= req_kind;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                word_q  <= req_word;
            end
            if (cap_lo_q) lo_q <= mem_out;
            if (cap_hi_q) hi_q <= mem_out;
            rsp_valid <= (state == DONE);
            if (state == DONE) begin
                case (kind_q)
                    K_FETCH: rsp_data <= {hi_q, lo_q};
                    // the last LOAD read cycle coincides with DONE
                    K_LOAD:  rsp_data <= {8'h00, mem_out};
                    default: rsp_data <= 16'h0000;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_memory_sequencer.sv
module tb_memory_sequencer;
    import memory_pkg::*;

    localparam int RC = 2;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           req_kind;
    logic [7:0]           req_addr;
    logic [7:0]           req_wdata;
    logic                 req_word;
    logic                 rsp_valid;
    logic [15:0]          rsp_data;
    memory_op_e           mem_op;
    memory_bus_selector_e mem_bus_sel;
    logic                 mem_word_sel;
    logic [7:0]           mem_in;
    logic [7:0]           mem_out;

    memory_sequencer #(.READ_CYCLES(RC)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_kind     (req_kind),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_word     (req_word),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .mem_op       (mem_op),
        .mem_bus_sel  (mem_bus_sel),
        .mem_word_sel (mem_word_sel),
        .mem_in       (mem_in),
        .mem_out      (mem_out)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // memory block model: PC/MAR registers and 2 bytes per address
    logic [7:0] mem_cells [512];
    logic [7:0] mem_pc = 8'h00;
    logic [7:0] mem_mar = 8'h00;
    logic [7:0] sel_reg;

    assign sel_reg = (mem_bus_sel == PC) ? mem_pc : mem_mar;
    assign mem_out = (mem_op == READ) ? mem_cells[{sel_reg, mem_word_sel}] : 8'h00;

    always @(posedge clock) begin
        case (mem_op)
            INC:      if (mem_bus_sel == PC) mem_pc <= mem_pc + 8'd1; else mem_mar <= mem_mar + 8'd1;
            ABSOLUTE: if (mem_bus_sel == PC) mem_pc <= mem_in;        else mem_mar <= mem_in;
            REL_ADD:  if (mem_bus_sel == PC) mem_pc <= mem_pc + mem_in; else mem_mar <= mem_mar + mem_in;
            REL_SUB:  if (mem_bus_sel == PC) mem_pc <= mem_pc - mem_in; else mem_mar <= mem_mar - mem_in;
            WRITE:    mem_cells[{mem_mar, mem_word_sel}] <= mem_in;
            default:  ;
        endcase
    end

    // reference model: architectural view of the memory as the control unit sees it
    logic [7:0] ref_cells [512];
    logic [7:0] ref_pc = 8'h00;

    typedef struct {
        logic [15:0] data;
        int unsigned due;
    } sb_entry_t;
    sb_entry_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic [2:0] kind, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic word, output logic [15:0] d, output int lat);
        d = 16'h0000;
        case (kind)
            3'd0: begin
                d = {ref_cells[{ref_pc, 1'b1}], ref_cells[{ref_pc, 1'b0}]};
                ref_pc = ref_pc + 8'd1;
                lat = 2 * RC + 2;
            end
            3'd1: begin ref_pc = addr;          lat = 2; end
            3'd2: begin ref_pc = ref_pc + addr; lat = 2; end
            3'd3: begin ref_pc = ref_pc - addr; lat = 2; end
            3'd4: begin d = {8'h00, ref_cells[{addr, word}]}; lat = RC + 2; end
            3'd5: begin ref_cells[{addr, word}] = wdata; lat = 3; end
            default: lat = 1;
        endcase
    endtask

    task automatic send(input logic [2:0] kind, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic word, output int unsigned acc);
        int n;
        int lat;
        sb_entry_t e;
        @(negedge clock);
        req_kind  = kind;
        req_addr  = addr;
        req_wdata = wdata;
        req_word  = word;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        acc = 0;
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready stayed 0, required 1");
            req_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            acc = cyc;
            req_valid = 1'b0;
            model(kind, addr, wdata, word, e.data, lat);
            e.due = acc + lat;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clock);
    endtask

    task automatic preload(input logic [8:0] idx, input logic [7:0] v);
        mem_cells[idx] = v;
        ref_cells[idx] = v;
    endtask

    // monitor: every response must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (reset_n && rsp_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: rsp_valid=1 data=%0h, required no response", rsp_data);
            end else begin
                sb_entry_t e;
                e = sb.pop_front();
                check("rsp_data", {16'h0, rsp_data}, {16'h0, e.data});
                check("rsp_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a0, a1;
        logic [7:0] saved_pc;
        logic [7:0] v;

        for (int i = 0; i < 512; i++) begin
            v = 8'($urandom);
            mem_cells[i] = v;
            ref_cells[i] = v;
        end
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_kind  = 3'd0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        req_word  = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("reset_mem_op", 32'(mem_op), 32'(NOP));
        check("reset_bus_sel", 32'(mem_bus_sel), 32'(MAR));
        check("reset_word_sel", 32'(mem_word_sel), 0);
        check("reset_mem_in", 32'(mem_in), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_data", 32'(rsp_data), 0);
        check("reset_req_ready", 32'(req_ready), 1);

        // fetch from PC 0
        preload(9'h000, 8'h34);
        preload(9'h001, 8'h12);
        send(3'd0, 8'h00, 8'h00, 1'b0, a0);
        drain();
        check("fetch_pc_after", 32'(mem_pc), 32'h01);

        // store then load back
        send(3'd5, 8'h05, 8'hA5, 1'b1, a0);
        send(3'd4, 8'h05, 8'h00, 1'b1, a0);
        drain();
        check("store_cell", 32'(mem_cells[{8'h05, 1'b1}]), 32'hA5);
        check("store_mar", 32'(mem_mar), 32'h05);

        // relative jump then fetch from the new PC
        send(3'd1, 8'h10, 8'h00, 1'b0, a0);
        send(3'd3, 8'h03, 8'h00, 1'b0, a0);
        preload({8'h0D, 1'b0}, 8'h5A);
        preload({8'h0D, 1'b1}, 8'hC3);
        send(3'd0, 8'h00, 8'h00, 1'b0, a0);
        drain();
        check("jump_sub_fetch_pc", 32'(mem_pc), 32'h0E);

        // FETCH held valid while STORE is busy: accepted only after DONE
        send(3'd5, 8'h22, 8'h3C, 1'b0, a0);
        send(3'd0, 8'h00, 8'h00, 1'b0, a1);
        check("busy_accept_gap", a1 - a0, 4);
        drain();

        // illegal kinds
        send(3'd6, 8'hFF, 8'hFF, 1'b1, a0);
        send(3'd7, 8'h11, 8'h22, 1'b0, a0);
        drain();

        // reset pulse during RD_HI aborts the fetch without a response
        saved_pc = ref_pc;
        send(3'd0, 8'h00, 8'h00, 1'b0, a0);
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        sb.delete();
        ref_pc = saved_pc;
        check("midrst_mem_op", 32'(mem_op), 32'(NOP));
        check("midrst_rsp_valid", 32'(rsp_valid), 0);
        check("midrst_rsp_data", 32'(rsp_data), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("midrst_req_ready", 32'(req_ready), 1);
        check("midrst_pc_kept", 32'(mem_pc), 32'(ref_pc));
        send(3'd0, 8'h00, 8'h00, 1'b0, a0);
        drain();
        check("post_rst_fetch_pc", 32'(mem_pc), 32'(ref_pc));

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom), a0);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        drain();
        check("rand_pc", 32'(mem_pc), 32'(ref_pc));
        for (int i = 0; i < 512; i++) begin
            if (mem_cells[i] !== ref_cells[i]) begin
                check("rand_cells", 32'(mem_cells[i]), 32'(ref_cells[i]));
            end
        end
        check("rand_cell_05", 32'(mem_cells[{8'h05, 1'b1}]), 32'(ref_cells[{8'h05, 1'b1}]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
